// File: rtl/lfsr_prng.sv
// lfsr_prng: parametrised right-shifting Fibonacci LFSR with a single-clock
// step-enable divider, run/hold control, runtime seed load with all-zero
// lock-up protection and a per-step strobe.
// Optional feature macro: LFSR_PERIOD_CHECK_EN (period-wrap detection).
module lfsr_prng #(
  parameter int unsigned       WIDTH = 5,
  parameter logic [WIDTH-1:0]  TAPS  = 5'b00101,
  parameter logic [WIDTH-1:0]  SEED  = 5'b01000,
  parameter int unsigned       DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div_count,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             step,
  output logic             lockup,
  output logic             wrapped
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             lockup_q, lockup_d;

  logic [DIV_W-1:0] limit;
  logic             due;
  logic             advance;
  logic             feedback;
  logic [WIDTH-1:0] next_state;

  // Divider limit and LFSR next-state; div_count is compared live every cycle.
  always_comb begin
    limit      = (div_count == '0) ? '0 : (div_count - DIV_W'(1));
    due        = (cnt_q >= limit);
    advance    = run && !load && due;
    feedback   = ^(state_q & TAPS);
    next_state = {feedback, state_q[WIDTH-1:1]};
  end

  // Next-state selection: load beats a due advance; run=0 freezes everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = 1'b0;
    lockup_d = 1'b0;
    if (load) begin
      cnt_d = '0;
      if (load_value == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = load_value;
      end
    end else if (run) begin
      if (due) begin
        state_d = next_state;
        cnt_d   = '0;
        step_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // Core registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= SEED;
      cnt_q    <= '0;
      step_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      lockup_q <= lockup_d;
    end
  end

  assign lfsr_out = state_q;
  assign step     = step_q;
  assign lockup   = lockup_q;

`ifdef LFSR_PERIOD_CHECK_EN
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] stepcnt_q, stepcnt_d;
  logic             wrapped_q, wrapped_d;

  // Wrap reference follows the value actually written by reset or load.
  always_comb begin
    ref_d     = ref_q;
    stepcnt_d = stepcnt_q;
    wrapped_d = 1'b0;
    if (load) begin
      ref_d     = state_d;
      stepcnt_d = '0;
    end else if (advance) begin
      if (next_state == ref_q) begin
        wrapped_d = 1'b1;
        stepcnt_d = '0;
      end else begin
        stepcnt_d = stepcnt_q + WIDTH'(1);
      end
    end
  end

  // Period-check registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_q     <= SEED;
      stepcnt_q <= '0;
      wrapped_q <= 1'b0;
    end else begin
      ref_q     <= ref_d;
      stepcnt_q <= stepcnt_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign wrapped = wrapped_q;
`else
  assign wrapped = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng (default parameters): a per-cycle
// expectation is queued when stimulus is driven and popped one edge later.
module tb_lfsr_prng;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] div_count;
  logic        load;
  logic [4:0]  load_value;
  logic [4:0]  lfsr_out;
  logic        step;
  logic        lockup;
  logic        wrapped;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] lfsr;
    logic       step;
    logic       lockup;
    logic       wrapped;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;

  // Bench-side reference state
  logic [4:0] m_state;
  logic [4:0] m_ref;
  int         m_ph;

  lfsr_prng #(
    .WIDTH(5),
    .TAPS (5'b00101),
    .SEED (5'b01000),
    .DIV_W(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .div_count (div_count),
    .load      (load),
    .load_value(load_value),
    .lfsr_out  (lfsr_out),
    .step      (step),
    .lockup    (lockup),
    .wrapped   (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // x^5 + x^2 + 1, right shift: new MSB = bit0 ^ bit2
  function automatic logic [4:0] nxt(input logic [4:0] s);
    return {s[0] ^ s[2], s[4:1]};
  endfunction

  // Drive one cycle of stimulus, queue what the DUT must show after the edge,
  // then return at the following falling edge.
  task automatic tick(input logic r, input logic ru, input logic [31:0] dv,
                      input logic ld, input logic [4:0] lv);
    exp_t e;
    int   lim;
    rst = r; run = ru; div_count = dv; load = ld; load_value = lv;
    e.step = 1'b0; e.lockup = 1'b0; e.wrapped = 1'b0;
    if (!r) begin
      m_state = 5'b01000; m_ref = 5'b01000; m_ph = 0;
    end else if (ld) begin
      m_ph = 0;
      if (lv == 5'd0) begin
        m_state = 5'b01000; e.lockup = 1'b1;
      end else begin
        m_state = lv;
      end
      m_ref = m_state;
    end else if (ru) begin
      lim = (dv == 0) ? 0 : int'(dv) - 1;
      if (m_ph >= lim) begin
        m_state = nxt(m_state);
        m_ph = 0;
        e.step = 1'b1;
`ifdef LFSR_PERIOD_CHECK_EN
        e.wrapped = (m_state == m_ref);
`endif
      end else begin
        m_ph++;
      end
    end
    e.lfsr = m_state;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard: compare each queued expectation just after its edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      checks++;
      if (lfsr_out !== sb_e.lfsr) begin
        failures++;
        $display("FAIL sb_lfsr_out t=%0t got=%b exp=%b", $time, lfsr_out, sb_e.lfsr);
      end
      checks++;
      if (step !== sb_e.step) begin
        failures++;
        $display("FAIL sb_step t=%0t got=%b exp=%b", $time, step, sb_e.step);
      end
      checks++;
      if (lockup !== sb_e.lockup) begin
        failures++;
        $display("FAIL sb_lockup t=%0t got=%b exp=%b", $time, lockup, sb_e.lockup);
      end
      checks++;
      if (wrapped !== sb_e.wrapped) begin
        failures++;
        $display("FAIL sb_wrapped t=%0t got=%b exp=%b", $time, wrapped, sb_e.wrapped);
      end
    end
  end

  task automatic test_reset();
    tick(1'b0, 1'b0, 32'd1, 1'b0, 5'd0);
    checks++;
    if (lfsr_out !== 5'b01000 || step !== 1'b0 || lockup !== 1'b0 || wrapped !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%b/%b%b%b exp=01000/000", lfsr_out, step, lockup, wrapped);
    end
  endtask

  task automatic test_sequence();
    logic [4:0] seq [4];
    seq[0] = 5'b00100; seq[1] = 5'b10010; seq[2] = 5'b01001; seq[3] = 5'b10100;
    tick(1'b0, 1'b0, 32'd1, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 32'd1, 1'b0, 5'd0);
      checks++;
      if (lfsr_out !== seq[i] || step !== 1'b1) begin
        failures++;
        $display("FAIL sequence_%0d got=%b step=%b exp=%b step=1", i, lfsr_out, step, seq[i]);
      end
    end
  endtask

  task automatic test_period();
    logic [31:0] seen;
    int wraps;
    int dups;
    seen = '0; wraps = 0; dups = 0;
    tick(1'b0, 1'b0, 32'd0, 1'b0, 5'd0);
    for (int i = 1; i <= 31; i++) begin
      tick(1'b1, 1'b1, 32'd0, 1'b0, 5'd0);
      if (lfsr_out == 5'd0 || seen[lfsr_out] === 1'b1) dups++;
      seen[lfsr_out] = 1'b1;
      if (wrapped === 1'b1) wraps++;
    end
    checks++;
    if (dups != 0) begin
      failures++;
      $display("FAIL period_distinct got=%0d repeats/zeros exp=0", dups);
    end
    checks++;
    if (lfsr_out !== 5'b01000) begin
      failures++;
      $display("FAIL period_return got=%b exp=01000", lfsr_out);
    end
    checks++;
`ifdef LFSR_PERIOD_CHECK_EN
    if (wraps != 1) begin
      failures++;
      $display("FAIL period_wraps got=%0d exp=1", wraps);
    end
`else
    if (wraps != 0) begin
      failures++;
      $display("FAIL period_wraps got=%0d exp=0", wraps);
    end
`endif
  endtask

  task automatic test_divider();
    int hits[$];
    tick(1'b0, 1'b0, 32'd5, 1'b0, 5'd0);
    for (int c = 1; c <= 20; c++) begin
      tick(1'b1, !(c >= 13 && c <= 15), 32'd5, 1'b0, 5'd0);
      if (step === 1'b1) hits.push_back(c);
    end
    checks++;
    if (hits.size() != 3 || hits[0] != 5 || hits[1] != 10 || hits[2] != 18) begin
      failures++;
      $display("FAIL divider_steps got=%p exp='{5,10,18}", hits);
    end
  endtask

  task automatic test_load();
    int hit;
    tick(1'b0, 1'b0, 32'd3, 1'b0, 5'd0);
    tick(1'b1, 1'b1, 32'd3, 1'b1, 5'b00000);
    checks++;
    if (lfsr_out !== 5'b01000 || lockup !== 1'b1 || step !== 1'b0) begin
      failures++;
      $display("FAIL load_zero got=%b lockup=%b step=%b exp=01000 1 0", lfsr_out, lockup, step);
    end
    tick(1'b1, 1'b1, 32'd3, 1'b1, 5'b10001);
    checks++;
    if (lfsr_out !== 5'b10001 || lockup !== 1'b0 || step !== 1'b0) begin
      failures++;
      $display("FAIL load_value got=%b lockup=%b step=%b exp=10001 0 0", lfsr_out, lockup, step);
    end
    hit = 0;
    for (int c = 1; c <= 3; c++) begin
      tick(1'b1, 1'b1, 32'd3, 1'b0, 5'd0);
      if (step === 1'b1 && hit == 0) hit = c;
    end
    checks++;
    if (hit != 3 || lfsr_out !== 5'b11000) begin
      failures++;
      $display("FAIL load_then_step got=cycle%0d/%b exp=cycle3/11000", hit, lfsr_out);
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b0, 1'b0, 32'd1, 1'b0, 5'd0);
    tick(1'b1, 1'b1, 32'd1, 1'b0, 5'd0);
    tick(1'b1, 1'b1, 32'd1, 1'b1, 5'b10110);
    checks++;
    if (lfsr_out !== 5'b10110 || step !== 1'b0) begin
      failures++;
      $display("FAIL load_vs_step got=%b step=%b exp=10110 0", lfsr_out, step);
    end
    tick(1'b1, 1'b1, 32'd1, 1'b0, 5'd0);
  endtask

  task automatic test_midreset();
    int hit;
    tick(1'b0, 1'b0, 32'd5, 1'b0, 5'd0);
    tick(1'b1, 1'b1, 32'd5, 1'b0, 5'd0);
    tick(1'b1, 1'b1, 32'd5, 1'b0, 5'd0);
    tick(1'b0, 1'b1, 32'd5, 1'b0, 5'd0);
    checks++;
    if (lfsr_out !== 5'b01000 || step !== 1'b0 || lockup !== 1'b0 || wrapped !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state got=%b/%b%b%b exp=01000/000", lfsr_out, step, lockup, wrapped);
    end
    hit = 0;
    for (int c = 1; c <= 6; c++) begin
      tick(1'b1, 1'b1, 32'd5, 1'b0, 5'd0);
      if (step === 1'b1 && hit == 0) hit = c;
    end
    checks++;
    if (hit != 5) begin
      failures++;
      $display("FAIL midreset_first_step got=cycle%0d exp=cycle5", hit);
    end
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; div_count = 32'd1; load = 1'b0; load_value = 5'd0;
    m_state = 5'b01000; m_ref = 5'b01000; m_ph = 0;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_period();
    test_divider();
    test_load();
    test_back_to_back();
    test_midreset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
